// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first, start/busy/done handshake
// Optional build macro: SERIAL_SUBTRACTOR_SAT_EN (clamp d to 0 when the final borrow is set)
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             br
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;

    logic             w_ai;
    logic             w_bi;
    logic             w_diff;
    logic             w_bout;
    logic [WIDTH-1:0] w_a_next;
    logic [WIDTH-1:0] w_d_final;

    assign w_ai   = r_a_sr[0];
    assign w_bi   = r_b_sr[0];
    assign w_diff = w_ai ^ w_bi ^ r_borrow;
    assign w_bout = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);

    // Difference bits enter the minuend register at the MSB as its consumed bits
    // leave at the LSB, so after WIDTH shifts it holds the complete result.
    generate
        if (WIDTH == 1) begin : g_w1
            assign w_a_next = w_diff;
        end else begin : g_wn
            assign w_a_next = {w_diff, r_a_sr[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIAL_SUBTRACTOR_SAT_EN
    assign w_d_final = w_bout ? '0 : w_a_next;
`else
    assign w_d_final = w_a_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            br       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a_sr   <= a;
                        r_b_sr   <= b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                        busy     <= 1'b1;
                        r_state  <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a_sr   <= w_a_next;
                    r_b_sr   <= r_b_sr >> 1;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        d       <= w_d_final;
                        br      <= w_bout;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8 and WIDTH=1)
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst   = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         br;

    logic         start1 = 1'b0;
    logic [0:0]   a1     = '0;
    logic [0:0]   b1     = '0;
    logic         busy1;
    logic         done1;
    logic [0:0]   d1;
    logic         br1;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .d(d), .br(br)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .br(br1)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         br;
        int           due;
    } exp_t;

    exp_t         q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_fail   = 0;
    int           cyc      = 0;
    logic [W-1:0] exp_d_hold  = '0;
    logic         exp_br_hold = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference: plain modular subtraction and an unsigned compare.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int due);
        exp_t e;
        e.d   = x - y;
        e.br  = (x < y);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
        if (e.br) e.d = '0;
`endif
        e.due = due;
        return e;
    endfunction

    // A request is taken whenever no result is outstanding; it completes WIDTH edges later.
    task automatic drive(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = s;
        a     = x;
        b     = y;
        if (s && !rst && q.size() == 0)
            q.push_back(model(x, y, cyc + 1 + W));
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
        drive(1'b1, x, y);
        for (int i = 0; i < W + 2; i++) drive(1'b0, 8'h00, 8'h00);
        check("op_drained", q.size(), 0);
    endtask

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            q.delete();
            exp_d_hold  = '0;
            exp_br_hold = 1'b0;
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
        end else begin
            if (done) begin
                if (q.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("done_latency", cyc, mon_e.due);
                    exp_d_hold  = mon_e.d;
                    exp_br_hold = mon_e.br;
                end
            end else if (q.size() > 0 && cyc >= q[0].due) begin
                check("missing_done", done, 1);
                void'(q.pop_front());
            end
            check("busy", busy, (q.size() > 0) ? 1 : 0);
        end
        check("d", d, exp_d_hold);
        check("br", br, exp_br_hold);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [1:0]   combo;
        logic [1:0]   diff1;

        repeat (3) @(negedge clk);
        rst = 1'b0;

        run_op(8'h5A, 8'h23);
        run_op(8'h00, 8'h01);
        run_op(8'hFF, 8'hFF);
        run_op(8'h10, 8'h80);

        // start held high with churning operands during RUN
        drive(1'b1, 8'h40, 8'h05);
        for (int i = 0; i < W; i++) drive(1'b1, W'($urandom), W'($urandom));
        drive(1'b0, 8'h00, 8'h00);
        for (int i = 0; i < W + 2; i++) drive(1'b0, 8'h00, 8'h00);
        check("hold_drained", q.size(), 0);

        // back-to-back: second start lands in the DONE cycle
        drive(1'b1, 8'hC8, 8'h64);
        for (int i = 0; i < W; i++) drive(1'b0, 8'h00, 8'h00);
        drive(1'b1, 8'h09, 8'h03);
        check("b2b_accept", q.size(), 1);
        for (int i = 0; i < W + 2; i++) drive(1'b0, 8'h00, 8'h00);

        // reset on the third RUN cycle aborts the operation
        drive(1'b1, 8'h33, 8'h11);
        drive(1'b0, 8'h00, 8'h00);
        drive(1'b0, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < W + 4; i++) drive(1'b0, 8'h00, 8'h00);

        for (int i = 0; i < 1500; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 7 == 0) rb = ra;
            if (i % 11 == 0) ra = '0;
            if (i % 13 == 0) rb = '1;
            drive(($urandom % 3) == 0, ra, rb);
        end
        for (int i = 0; i < W + 2; i++) drive(1'b0, 8'h00, 8'h00);
        check("random_drained", q.size(), 0);

        for (int i = 0; i < 4; i++) begin
            combo = 2'(i);
            @(negedge clk);
            start1 = 1'b1;
            a1     = combo[1];
            b1     = combo[0];
            @(negedge clk);
            start1 = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                if (done1) break;
            end
            diff1 = {1'b0, combo[1]} - {1'b0, combo[0]};
            check("w1_done", done1, 1);
            check("w1_br", br1, (combo[1] < combo[0]) ? 1 : 0);
`ifdef SERIAL_SUBTRACTOR_SAT_EN
            check("w1_d", d1, (combo[1] < combo[0]) ? 0 : diff1[0]);
`else
            check("w1_d", d1, diff1[0]);
`endif
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
